instruction_fetch_unit: RTL and testbench

Front end of the VSM CPU: fetches 16-bit instruction words from program memory over a request/acknowledge port and holds them in the instruction register. It presents `OpCode`/`IRData` to the control unit and generates the `StepCounterReset` pulse that starts each instruction's micro-step sequence. It consumes the control unit's end-of-instruction, jump and halt indications to sequence the next fetch.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/program_counter.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the VSM CPU front end: instruction field widths
// and the fetch-sequencer state encoding.
package cpu_pkg;

    localparam int OPCODE_W = 5;
    localparam int IRDATA_W = 11;
    localparam int INSTR_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] ir_opcode(input logic [INSTR_W-1:0] ir);
        return ir[INSTR_W-1 -: OPCODE_W];
    endfunction

    function automatic logic [IRDATA_W-1:0] ir_data(input logic [INSTR_W-1:0] ir);
        return ir[IRDATA_W-1:0];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment, and the
// increment wraps naturally modulo 2^ADDR_W.
module program_counter
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inc,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus1;

    assign w_pc_plus1 = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

    // PC update: jump target beats the sequential increment
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// VSM CPU instruction fetch unit: fetch sequencer, instruction register and
// step-counter reset pulse in front of the control unit.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic                Clk,
    input  logic                Rst,
    output logic                MemReq,
    output logic [ADDR_W-1:0]   MemAddr,
    input  logic                MemAck,
    input  logic [INSTR_W-1:0]  MemData,
    input  logic                InstrDone,
    input  logic                JumpEn,
    input  logic [ADDR_W-1:0]   JumpAddr,
    input  logic                Halt,
    output logic [OPCODE_W-1:0] OpCode,
    output logic [IRDATA_W-1:0] IRData,
    output logic                StepCounterReset,
    output logic                InstrValid,
    output logic [ADDR_W-1:0]   PC
);

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [INSTR_W-1:0] r_ir;
    logic               r_mem_req;
    logic               r_instr_valid;
    logic               r_step_rst;
    logic               w_ack_fire;
    logic               w_done_fire;
    logic               w_jump;
    logic [ADDR_W-1:0]  w_pc;

    // Inputs only take effect in the state that owns them
    assign w_ack_fire  = (r_state == FETCH) && MemAck;
    assign w_done_fire = (r_state == EXEC) && InstrDone;
    assign w_jump      = w_done_fire && JumpEn;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                if (MemAck) begin
                    w_next_state = EXEC;
                end else begin
                    w_next_state = FETCH;
                end
            end
            EXEC: begin
                if (InstrDone) begin
                    w_next_state = Halt ? HALTED : FETCH;
                end else begin
                    w_next_state = EXEC;
                end
            end
            HALTED: begin
                if (!Halt) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = HALTED;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, IR and registered strobes; outputs are decoded from the next state
    // so MemReq/InstrValid are flops that clear asynchronously with Rst
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state       <= IDLE;
            r_ir          <= 16'h0000;
            r_mem_req     <= 1'b0;
            r_instr_valid <= 1'b0;
            r_step_rst    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_ir          <= w_ack_fire ? MemData : r_ir;
            r_mem_req     <= (w_next_state == FETCH);
            r_instr_valid <= (w_next_state == EXEC);
            r_step_rst    <= w_ack_fire;
        end
    end

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_inc      (w_ack_fire),
        .i_load     (w_jump),
        .i_load_val (JumpAddr),
        .o_pc       (w_pc)
    );

    assign MemReq           = r_mem_req;
    assign MemAddr          = w_pc;
    assign PC               = w_pc;
    assign OpCode           = ir_opcode(r_ir);
    assign IRData           = ir_data(r_ir);
    assign StepCounterReset = r_step_rst;
    assign InstrValid       = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: the bench plays program
// memory and control unit, tracking the expected PC/IR at transaction level.
module tb_instruction_fetch_unit;
    import cpu_pkg::*;

    localparam int AW = 11;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          MemReq;
    logic [AW-1:0] MemAddr;
    logic          MemAck;
    logic [15:0]   MemData;
    logic          InstrDone;
    logic          JumpEn;
    logic [AW-1:0] JumpAddr;
    logic          Halt;
    logic [4:0]    OpCode;
    logic [10:0]   IRData;
    logic          StepCounterReset;
    logic          InstrValid;
    logic [AW-1:0] PC;

    int checks = 0;
    int errors = 0;

    // Expected architectural state
    logic [AW-1:0] m_pc;
    logic [15:0]   m_ir;

    instruction_fetch_unit #(.ADDR_W(AW), .RESET_PC(11'h000)) dut (
        .Clk(Clk), .Rst(Rst), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemData(MemData), .InstrDone(InstrDone), .JumpEn(JumpEn), .JumpAddr(JumpAddr),
        .Halt(Halt), .OpCode(OpCode), .IRData(IRData), .StepCounterReset(StepCounterReset),
        .InstrValid(InstrValid), .PC(PC)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; MemAck = 1'b0; MemData = 16'h0000; InstrDone = 1'b0;
        JumpEn = 1'b0; JumpAddr = 11'h000; Halt = 1'b0;
        tick(); tick();
        checks++;
        if ({MemReq, InstrValid, StepCounterReset, PC, OpCode, IRData} !== {1'b0, 1'b0, 1'b0, 11'h000, 5'h00, 11'h000}) begin
            errors++;
            $display("FAIL reset_values got req=%b iv=%b scr=%b pc=%h ir=%h exp 0/0/0/000/0000",
                     MemReq, InstrValid, StepCounterReset, PC, {OpCode, IRData});
        end
    endtask

    // Entered with Rst asserted; releases it with a stale MemAck present,
    // then performs a zero-wait fetch of 16'h0805 at address 0.
    task automatic test_first_fetch();
        MemAck = 1'b1; MemData = 16'hFFFF; InstrDone = 1'b0; JumpEn = 1'b0; Halt = 1'b0;
        Rst = 1'b0;
        tick();
        checks++;
        if ({MemReq, MemAddr, PC, OpCode, IRData, InstrValid} !== {1'b1, 11'h000, 11'h000, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL first_req got req=%b addr=%h pc=%h ir=%h iv=%b exp 1/000/000/0000/0",
                     MemReq, MemAddr, PC, {OpCode, IRData}, InstrValid);
        end
        MemData = 16'h0805;
        tick();
        MemAck = 1'b0;
        checks++;
        if ({OpCode, IRData, StepCounterReset, InstrValid, PC, MemReq} !== {5'h01, 11'h005, 1'b1, 1'b1, 11'h001, 1'b0}) begin
            errors++;
            $display("FAIL first_load got op=%h data=%h scr=%b iv=%b pc=%h req=%b exp 01/005/1/1/001/0",
                     OpCode, IRData, StepCounterReset, InstrValid, PC, MemReq);
        end
        tick();
        checks++;
        if ({StepCounterReset, InstrValid, OpCode, IRData} !== {1'b0, 1'b1, 16'h0805}) begin
            errors++;
            $display("FAIL first_pulse_end got scr=%b iv=%b ir=%h exp 0/1/0805",
                     StepCounterReset, InstrValid, {OpCode, IRData});
        end
        m_pc = 11'h001;
        m_ir = 16'h0805;
    endtask

    task automatic test_latency();
        int scr_seen;
        logic [15:0] d;
        scr_seen = 0;
        InstrDone = 1'b1; JumpEn = 1'b1; JumpAddr = 11'h000;
        tick();
        InstrDone = 1'b0; JumpEn = 1'b0;
        m_pc = 11'h000;
        for (int i = 0; i < 3; i++) begin
            scr_seen += int'(StepCounterReset);
            checks++;
            if ({MemReq, MemAddr, OpCode, IRData, InstrValid} !== {1'b1, m_pc, m_ir, 1'b0}) begin
                errors++;
                $display("FAIL latency_hold[%0d] got req=%b addr=%h ir=%h iv=%b exp 1/%h/%h/0",
                         i, MemReq, MemAddr, {OpCode, IRData}, InstrValid, m_pc, m_ir);
            end
            if (i < 2) tick();
        end
        d = 16'($urandom);
        MemAck = 1'b1; MemData = d;
        tick();
        MemAck = 1'b0;
        m_ir = d; m_pc = m_pc + 11'h001;
        scr_seen += int'(StepCounterReset);
        checks++;
        if ({OpCode, IRData, PC} !== {m_ir, m_pc}) begin
            errors++;
            $display("FAIL latency_load got ir=%h pc=%h exp %h/%h", {OpCode, IRData}, PC, m_ir, m_pc);
        end
        tick();
        scr_seen += int'(StepCounterReset);
        checks++;
        if (scr_seen !== 1) begin
            errors++;
            $display("FAIL latency_pulse_count got %0d exp 1", scr_seen);
        end
    endtask

    task automatic test_jump();
        logic [15:0] d;
        InstrDone = 1'b1; JumpEn = 1'b1; JumpAddr = 11'h3A0;
        tick();
        InstrDone = 1'b0; JumpEn = 1'b0;
        checks++;
        if ({MemReq, MemAddr} !== {1'b1, 11'h3A0}) begin
            errors++;
            $display("FAIL jump_addr got req=%b addr=%h exp 1/3a0", MemReq, MemAddr);
        end
        d = 16'($urandom);
        MemAck = 1'b1; MemData = d;
        tick();
        MemAck = 1'b0;
        m_pc = 11'h3A1; m_ir = d;
        checks++;
        if ({PC, OpCode, IRData, StepCounterReset} !== {11'h3A1, d, 1'b1}) begin
            errors++;
            $display("FAIL jump_after_fetch got pc=%h ir=%h scr=%b exp 3a1/%h/1", PC, {OpCode, IRData}, StepCounterReset, d);
        end
    endtask

    task automatic test_wrap();
        InstrDone = 1'b1; JumpEn = 1'b1; JumpAddr = 11'h7FF;
        tick();
        InstrDone = 1'b0; JumpEn = 1'b0;
        checks++;
        if (MemAddr !== 11'h7FF) begin
            errors++;
            $display("FAIL wrap_req got addr=%h exp 7ff", MemAddr);
        end
        MemAck = 1'b1; MemData = 16'hA5A5;
        tick();
        MemAck = 1'b0;
        checks++;
        if (PC !== 11'h000) begin
            errors++;
            $display("FAIL wrap_pc got pc=%h exp 000", PC);
        end
        InstrDone = 1'b1;
        tick();
        InstrDone = 1'b0;
        checks++;
        if ({MemReq, MemAddr} !== {1'b1, 11'h000}) begin
            errors++;
            $display("FAIL wrap_next_req got req=%b addr=%h exp 1/000", MemReq, MemAddr);
        end
        MemAck = 1'b1; MemData = 16'h1234;
        tick();
        MemAck = 1'b0;
        m_pc = 11'h001; m_ir = 16'h1234;
    endtask

    task automatic test_halt();
        InstrDone = 1'b1; Halt = 1'b1;
        tick();
        InstrDone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({MemReq, InstrValid, StepCounterReset, PC, OpCode, IRData} !== {1'b0, 1'b0, 1'b0, m_pc, m_ir}) begin
                errors++;
                $display("FAIL halt_hold[%0d] got req=%b iv=%b scr=%b pc=%h ir=%h exp 0/0/0/%h/%h",
                         i, MemReq, InstrValid, StepCounterReset, PC, {OpCode, IRData}, m_pc, m_ir);
            end
            MemAck = 1'($urandom); InstrDone = 1'($urandom); JumpEn = 1'b1;
            JumpAddr = 11'($urandom); MemData = 16'($urandom);
            tick();
        end
        MemAck = 1'b0; InstrDone = 1'b0; JumpEn = 1'b0; Halt = 1'b0;
        tick();
        checks++;
        if ({MemReq, MemAddr, OpCode, IRData} !== {1'b1, m_pc, m_ir}) begin
            errors++;
            $display("FAIL halt_resume got req=%b addr=%h ir=%h exp 1/%h/%h", MemReq, MemAddr, {OpCode, IRData}, m_pc, m_ir);
        end
        MemAck = 1'b1; MemData = 16'h4321;
        tick();
        MemAck = 1'b0;
        m_pc = m_pc + 11'h001; m_ir = 16'h4321;
    endtask

    // Random instruction stream: jumps, memory latency and spurious acks in EXEC
    task automatic test_random();
        logic [15:0] d;
        int ew, lat;
        bit je;
        logic [AW-1:0] ja;
        for (int n = 0; n < 40; n++) begin
            ew = int'($urandom_range(0, 2));
            for (int k = 0; k < ew; k++) begin
                tick();
                checks++;
                if ({InstrValid, MemReq, StepCounterReset, OpCode, IRData, PC} !== {1'b1, 1'b0, 1'b0, m_ir, m_pc}) begin
                    errors++;
                    $display("FAIL rand_exec[%0d] got iv=%b req=%b scr=%b ir=%h pc=%h exp 1/0/0/%h/%h",
                             n, InstrValid, MemReq, StepCounterReset, {OpCode, IRData}, PC, m_ir, m_pc);
                end
                MemAck = 1'($urandom); MemData = 16'($urandom);
            end
            MemAck = 1'b0;
            je = 1'($urandom); ja = 11'($urandom);
            InstrDone = 1'b1; JumpEn = je; JumpAddr = ja;
            tick();
            InstrDone = 1'b0; JumpEn = 1'b0;
            if (je) m_pc = ja;
            lat = int'($urandom_range(0, 3));
            for (int k = 0; k <= lat; k++) begin
                checks++;
                if ({MemReq, MemAddr, InstrValid} !== {1'b1, m_pc, 1'b0}) begin
                    errors++;
                    $display("FAIL rand_req[%0d] got req=%b addr=%h iv=%b exp 1/%h/0", n, MemReq, MemAddr, InstrValid, m_pc);
                end
                if (k < lat) tick();
            end
            d = 16'($urandom);
            MemAck = 1'b1; MemData = d;
            tick();
            MemAck = 1'b0;
            m_ir = d; m_pc = m_pc + 11'h001;
            checks++;
            if ({OpCode, IRData, PC, StepCounterReset, InstrValid} !== {m_ir, m_pc, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL rand_load[%0d] got ir=%h pc=%h scr=%b iv=%b exp %h/%h/1/1",
                         n, {OpCode, IRData}, PC, StepCounterReset, InstrValid, m_ir, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        InstrDone = 1'b1;
        tick();
        InstrDone = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if ({MemReq, InstrValid, PC, OpCode, IRData} !== {1'b0, 1'b0, 11'h000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid_fetch got req=%b iv=%b pc=%h ir=%h exp 0/0/000/0000", MemReq, InstrValid, PC, {OpCode, IRData});
        end
        tick();
        test_first_fetch();
        #2;
        Rst = 1'b1;
        #1;
        checks++;
        if ({MemReq, InstrValid, PC, OpCode, IRData} !== {1'b0, 1'b0, 11'h000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid_exec got req=%b iv=%b pc=%h ir=%h exp 0/0/000/0000", MemReq, InstrValid, PC, {OpCode, IRData});
        end
        tick();
        test_first_fetch();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_latency();
        test_jump();
        test_wrap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
